// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID->EX pipeline register.
//   ALU_SEL_BUS / ALU_OP_BUS : default widths of the ALU select / op fields
//   OP_NOP, SEL_NOP, NOP_REG_ADDR, zeroWord, NOTINDELAYSLOT : NOP bundle values
//   RstEnable                : level of rst that resets (active-low)
//   bundle_w()               : packed bundle width for a given set of field widths
package id_ex_pipe_pkg;

  localparam int ALU_SEL_BUS = 3;
  localparam int ALU_OP_BUS  = 8;

  localparam logic [ALU_OP_BUS-1:0]  OP_NOP         = 8'h00;
  localparam logic [ALU_SEL_BUS-1:0] SEL_NOP        = 3'b000;
  localparam logic [4:0]             NOP_REG_ADDR   = 5'b00000;
  localparam logic [31:0]            zeroWord       = 32'h0000_0000;
  localparam logic                   NOTINDELAYSLOT = 1'b0;
  localparam logic                   RstEnable      = 1'b0;

  // inst, reg1, reg2, link_addr are DATA_W wide; wreg, in_delay, next_delay are 1 bit.
  function automatic int bundle_w(input int data_w, input int reg_addr_w,
                                  input int alusel_w, input int aluop_w);
    return 4 * data_w + reg_addr_w + alusel_w + aluop_w + 3;
  endfunction

  localparam int BUNDLE_W = bundle_w(32, 5, ALU_SEL_BUS, ALU_OP_BUS);

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID->EX bus: decode-side bundle with valid/ready, and EX-side bundle with
// valid/ready.
// Handshake: a bundle moves on a side exactly in a cycle where its valid and
// ready are both 1 at the rising edge; valid never depends on ready, and a
// bundle offered with valid = 1 is held stable until it is taken.
//   master : the surrounding pipeline (drives id_* and ex_ready)
//   slave  : id_ex_pipe (drives id_ready and the ex_* bundle)
interface id_ex_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUSEL_W   = 3,
  parameter int ALUOP_W    = 8
);
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_W-1:0]     id_inst;
  logic [ALUSEL_W-1:0]   id_alusel;
  logic [ALUOP_W-1:0]    id_aluop;
  logic [DATA_W-1:0]     id_reg1;
  logic [DATA_W-1:0]     id_reg2;
  logic [REG_ADDR_W-1:0] id_wd;
  logic                  id_wreg;
  logic                  in_delay_i;
  logic [DATA_W-1:0]     link_addr_i;
  logic                  next_delay_i;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_W-1:0]     ex_inst;
  logic [ALUSEL_W-1:0]   ex_alusel;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [DATA_W-1:0]     ex_reg1;
  logic [DATA_W-1:0]     ex_reg2;
  logic [REG_ADDR_W-1:0] ex_wd;
  logic                  ex_wreg;
  logic                  in_delay_o;
  logic [DATA_W-1:0]     link_addr_o;
  logic                  next_delay_o;

  modport master (
    output id_valid, id_inst, id_alusel, id_aluop, id_reg1, id_reg2, id_wd,
           id_wreg, in_delay_i, link_addr_i, next_delay_i, ex_ready,
    input  id_ready, ex_valid, ex_inst, ex_alusel, ex_aluop, ex_reg1, ex_reg2,
           ex_wd, ex_wreg, in_delay_o, link_addr_o, next_delay_o
  );

  modport slave (
    input  id_valid, id_inst, id_alusel, id_aluop, id_reg1, id_reg2, id_wd,
           id_wreg, in_delay_i, link_addr_i, next_delay_i, ex_ready,
    output id_ready, ex_valid, ex_inst, ex_alusel, ex_aluop, ex_reg1, ex_reg2,
           ex_wd, ex_wreg, in_delay_o, link_addr_o, next_delay_o
  );
endinterface

// File: rtl/id_ex_pipe_skid_reg.sv
// pipe_skid_reg: generic W-bit valid/ready register with a one-entry skid.
//   clk, rst      : clock, synchronous active-low reset
//   clr_i         : synchronous clear of both entries (drops same-cycle input)
//   nop_i         : bundle value presented on out_data_o when empty
//   in_valid_i/in_ready_o/in_data_i    : upstream side, in_ready_o is a flop
//   out_valid_o/out_ready_i/out_data_o : downstream side, main entry
module pipe_skid_reg
  import id_ex_pipe_pkg::*;
#(
  parameter int W = BUNDLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] nop_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] main_q, main_d;
  logic         main_valid_q, main_valid_d;
  logic [W-1:0] skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q, ready_d;
  logic         accept, consume;

  assign accept  = in_valid_i & ready_q;
  assign consume = main_valid_q & out_ready_i;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || consume) begin
      if (skid_valid_q) begin
        // Skid drains first; ready_q is 0 here so no input can be accepted.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        // Bubble: downstream always sees the NOP bundle.
        main_d       = nop_i;
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
    // Ready is registered from the next skid state, so it never sees out_ready_i
    // combinationally.
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr_i) begin
      main_q       <= nop_i;
      main_valid_q <= 1'b0;
      skid_q       <= nop_i;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline register with valid/ready on both sides,
// one-entry skid buffer, synchronous flush and a saturating bubble counter.
//   clk        : clock
//   rst        : synchronous active-low reset
//   flush      : kill all held entries (and any same-cycle input)
//   bus        : id_ex_pipe_if slave (id_* bundle in, ex_* bundle out)
//   bubble_cnt : cycles with ex_valid = 0 since reset, saturating
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUSEL_W   = ALU_SEL_BUS,
  parameter int ALUOP_W    = ALU_OP_BUS,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_ex_pipe_if.slave      bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int BW = bundle_w(DATA_W, REG_ADDR_W, ALUSEL_W, ALUOP_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] out_bundle;
  logic [BW-1:0] nop_bundle;
  logic          ex_valid;

  // Field order is shared by pack, unpack and the NOP constant.
  assign in_bundle = {bus.id_inst, bus.id_alusel, bus.id_aluop, bus.id_reg1,
                      bus.id_reg2, bus.id_wd, bus.id_wreg, bus.in_delay_i,
                      bus.link_addr_i, bus.next_delay_i};

  assign nop_bundle = {DATA_W'(zeroWord), ALUSEL_W'(SEL_NOP), ALUOP_W'(OP_NOP),
                       DATA_W'(zeroWord), DATA_W'(zeroWord),
                       REG_ADDR_W'(NOP_REG_ADDR), 1'b0, NOTINDELAYSLOT,
                       DATA_W'(zeroWord), NOTINDELAYSLOT};

  pipe_skid_reg #(
    .W (BW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush),
    .nop_i       (nop_bundle),
    .in_valid_i  (bus.id_valid),
    .in_ready_o  (bus.id_ready),
    .in_data_i   (in_bundle),
    .out_valid_o (ex_valid),
    .out_ready_i (bus.ex_ready),
    .out_data_o  (out_bundle)
  );

  assign bus.ex_valid = ex_valid;
  assign {bus.ex_inst, bus.ex_alusel, bus.ex_aluop, bus.ex_reg1, bus.ex_reg2,
          bus.ex_wd, bus.ex_wreg, bus.in_delay_o, bus.link_addr_o,
          bus.next_delay_o} = out_bundle;

  // Bubble counter: counts through flush, cleared only by reset.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!ex_valid && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 3;
  localparam int OW = 8;
  localparam int CW = 16;
  localparam int BW = 4 * DW + RW + SW + OW + 3;
  localparam logic [BW-1:0] NOP_B = '0;   // every NOP field value is zero
  localparam logic [CW-1:0] CNT_MAX = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] bubble_cnt;
  logic [3:0]    small_cnt;

  id_ex_pipe_if #(.DATA_W(DW), .REG_ADDR_W(RW), .ALUSEL_W(SW), .ALUOP_W(OW)) bus ();
  id_ex_pipe_if #(.DATA_W(DW), .REG_ADDR_W(RW), .ALUSEL_W(SW), .ALUOP_W(OW)) sbus ();

  id_ex_pipe #(.DATA_W(DW), .REG_ADDR_W(RW), .ALUSEL_W(SW), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .bubble_cnt(bubble_cnt)
  );

  // Idle copy with a 4-bit counter for the saturation check.
  id_ex_pipe #(.DATA_W(DW), .REG_ADDR_W(RW), .ALUSEL_W(SW), .ALUOP_W(OW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(1'b0), .bus(sbus), .bubble_cnt(small_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];     // bundles held by the pipe, oldest first (max 2)
  logic [CW-1:0] m_cnt = '0;

  function automatic logic [BW-1:0] in_pack();
    return {bus.id_inst, bus.id_alusel, bus.id_aluop, bus.id_reg1, bus.id_reg2,
            bus.id_wd, bus.id_wreg, bus.in_delay_i, bus.link_addr_i, bus.next_delay_i};
  endfunction

  function automatic logic [BW-1:0] out_pack();
    return {bus.ex_inst, bus.ex_alusel, bus.ex_aluop, bus.ex_reg1, bus.ex_reg2,
            bus.ex_wd, bus.ex_wreg, bus.in_delay_o, bus.link_addr_o, bus.next_delay_o};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock: model updates from the pre-edge inputs, outputs are
  // sampled 1 time unit after the edge.
  task automatic step();
    int  size;
    bit  acc, cons;
    size = exp_q.size();
    acc  = bus.id_valid && (size < 2);
    cons = (size > 0) && bus.ex_ready;
    if (!rst) begin
      exp_q.delete();
      m_cnt = '0;
    end else begin
      if (size == 0 && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
      if (flush) exp_q.delete();
      else begin
        if (cons) void'(exp_q.pop_front());
        if (acc)  exp_q.push_back(in_pack());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic r, input logic [DW-1:0] r1);
    bus.id_valid     = v;
    bus.ex_ready     = r;
    bus.id_reg1      = r1;
    bus.id_reg2      = ~r1;
    bus.id_inst      = r1 + 32'h100;
    bus.id_wd        = r1[RW-1:0];
    bus.id_wreg      = 1'b1;
    bus.id_aluop     = 8'h21;
    bus.id_alusel    = 3'd1;
    bus.in_delay_i   = 1'b0;
    bus.link_addr_i  = '0;
    bus.next_delay_i = 1'b0;
  endtask

  typedef struct packed {
    logic          v;
    logic          r;
    logic          fl;
    logic [DW-1:0] r1;
    logic          e_v;
    logic          e_rdy;
    logic [DW-1:0] e_r1;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // idle companion
    sbus.id_valid = 0; sbus.ex_ready = 0; sbus.id_inst = '0; sbus.id_alusel = '0;
    sbus.id_aluop = '0; sbus.id_reg1 = '0; sbus.id_reg2 = '0; sbus.id_wd = '0;
    sbus.id_wreg = 0; sbus.in_delay_i = 0; sbus.link_addr_i = '0; sbus.next_delay_i = 0;

    // streaming
    tbl[0]  = '{1, 1, 0, 32'h1,  1, 1, 32'h1};
    tbl[1]  = '{1, 1, 0, 32'h2,  1, 1, 32'h2};
    tbl[2]  = '{1, 1, 0, 32'h3,  1, 1, 32'h3};
    tbl[3]  = '{1, 1, 0, 32'h4,  1, 1, 32'h4};
    tbl[4]  = '{0, 1, 0, 32'h0,  0, 1, 32'h0};
    // backpressure / skid
    tbl[5]  = '{1, 0, 0, 32'hA,  1, 1, 32'hA};
    tbl[6]  = '{1, 0, 0, 32'hB,  1, 0, 32'hA};
    tbl[7]  = '{1, 0, 0, 32'h77, 1, 0, 32'hA};
    tbl[8]  = '{0, 1, 0, 32'h0,  1, 1, 32'hB};
    tbl[9]  = '{0, 1, 0, 32'h0,  0, 1, 32'h0};
    // flush with both entries full and an input offered
    tbl[10] = '{1, 0, 0, 32'h1A, 1, 1, 32'h1A};
    tbl[11] = '{1, 0, 0, 32'h1B, 1, 0, 32'h1A};
    tbl[12] = '{1, 0, 1, 32'hC,  0, 1, 32'h0};
    tbl[13] = '{0, 1, 0, 32'h0,  0, 1, 32'h0};

    // ---- reset ----
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h5);
    step();
    step();
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ex_aluop", bus.ex_aluop, 8'h00);
    chk("rst_ex_wreg", bus.ex_wreg, 1'b0);
    chk("rst_id_ready", bus.id_ready, 1'b1);
    chk("rst_bubble_cnt", bubble_cnt, 16'd0);
    chk("rst_bundle", out_pack(), NOP_B);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("idle5_bubble_cnt", bubble_cnt, 16'd5);
    chk("idle5_small_cnt", small_cnt, 4'd5);

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].r1);
      flush = tbl[i].fl;
      step();
      flush = 1'b0;
      chk($sformatf("tbl%0d_ex_valid", i), bus.ex_valid, tbl[i].e_v);
      chk($sformatf("tbl%0d_id_ready", i), bus.id_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ex_reg1", i), bus.ex_reg1, tbl[i].e_r1);
      chk($sformatf("tbl%0d_ex_wreg", i), bus.ex_wreg, tbl[i].e_v);
      chk($sformatf("tbl%0d_ex_wd", i), bus.ex_wd, tbl[i].e_v ? tbl[i].e_r1[RW-1:0] : 5'd0);
      chk($sformatf("tbl%0d_ex_aluop", i), bus.ex_aluop, tbl[i].e_v ? 8'h21 : 8'h00);
    end

    // ---- delay-slot fields, held under backpressure ----
    drive(1'b1, 1'b0, 32'h55);
    bus.in_delay_i   = 1'b1;
    bus.next_delay_i = 1'b1;
    bus.link_addr_i  = 32'h0000_0048;
    step();
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ds%0d_ex_valid", i), bus.ex_valid, 1'b1);
      chk($sformatf("ds%0d_in_delay", i), bus.in_delay_o, 1'b1);
      chk($sformatf("ds%0d_next_delay", i), bus.next_delay_o, 1'b1);
      chk($sformatf("ds%0d_link", i), bus.link_addr_o, 32'h48);
      chk($sformatf("ds%0d_reg1", i), bus.ex_reg1, 32'h55);
      if (i < 3) step();
    end
    bus.ex_ready = 1'b1;
    step();
    chk("ds_drain_ex_valid", bus.ex_valid, 1'b0);
    chk("ds_drain_in_delay", bus.in_delay_o, 1'b0);
    chk("ds_drain_link", bus.link_addr_o, 32'h0);

    // ---- randomized, checked against the queue model ----
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom);
      bus.id_inst      = $urandom;
      bus.id_reg2      = $urandom;
      bus.id_wd        = RW'($urandom_range(0, 31));
      bus.id_wreg      = 1'($urandom_range(0, 1));
      bus.id_aluop     = OW'($urandom_range(0, 255));
      bus.id_alusel    = SW'($urandom_range(0, 7));
      bus.in_delay_i   = 1'($urandom_range(0, 1));
      bus.next_delay_i = 1'($urandom_range(0, 1));
      bus.link_addr_i  = $urandom;
      flush = ($urandom_range(0, 24) == 0);
      step();
      flush = 1'b0;
      chk("rnd_ex_valid", bus.ex_valid, exp_q.size() != 0);
      chk("rnd_id_ready", bus.id_ready, exp_q.size() < 2);
      chk("rnd_bundle", out_pack(), (exp_q.size() != 0) ? exp_q[0] : NOP_B);
      chk("rnd_bubble_cnt", bubble_cnt, m_cnt);
    end

    // ---- saturation of the 4-bit counter (far more than 20 idle cycles) ----
    chk("sat_small_cnt", small_cnt, 4'd15);
    step();
    chk("sat_small_cnt_nowrap", small_cnt, 4'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
